// File: rtl/bcd_ascii_streamer_if.sv
// Character-stream bundle for bcd_ascii_streamer: frame request, packed digits,
// the ASCII valid/ready stream and frame status.
interface bcd_ascii_streamer_if #(
    parameter int DIGITS = 8
);
    // Handshake: a character moves only on a rising edge where Ascii_valid and
    // Ascii_ready are both 1; the source holds Ascii_out stable until then.
    logic                  Start;
    logic [4*DIGITS-1:0]   Bcd_in;
    logic [7:0]            Ascii_out;
    logic                  Ascii_valid;
    logic                  Ascii_ready;
    logic                  Busy;
    logic                  Done;
    logic                  Err;

    modport master (
        output Start, Bcd_in, Ascii_ready,
        input  Ascii_out, Ascii_valid, Busy, Done, Err
    );

    modport slave (
        input  Start, Bcd_in, Ascii_ready,
        output Ascii_out, Ascii_valid, Busy, Done, Err
    );
endinterface

// File: rtl/bcd_ascii_streamer.sv
// Streams a latched frame of BCD digits as ASCII characters, MSD first.
// Define BCD_ASCII_CRLF_EN to append CR, LF to every frame.
module bcd_ascii_streamer #(
    parameter int DIGITS   = 8,
    parameter int BLANK_LZ = 1,
    parameter int HEX_MODE = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    bcd_ascii_streamer_if.slave  bus,
    output logic [1:0]           state_dbg
);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic ONE_DIGIT = (DIGITS == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
`ifdef BCD_ASCII_CRLF_EN
        S_TERM = 2'd2,
`endif
        S_FIN  = 2'd3
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] shadow;
    logic [IDXW-1:0]     idx;
    logic                seen_nz;
    logic [7:0]          ascii_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
`ifdef BCD_ASCII_CRLF_EN
    logic                lf_phase;
`endif

    // Returns {invalid, character}; invalid nibbles count as nonzero for blanking.
    function automatic logic [8:0] map_nibble(input logic [3:0] nib,
                                              input logic seen,
                                              input logic last);
        logic [8:0] r;
        r = '0;
        if (nib == 4'd0 && !seen && BLANK_LZ != 0 && !last)
            r = {1'b0, 8'd32};
        else if (nib < 4'd10)
            r = {1'b0, 8'd48 + {4'd0, nib}};
        else if (HEX_MODE != 0)
            r = {1'b0, 8'd55 + {4'd0, nib}};
        else
            r = {1'b1, 8'd63};
        return r;
    endfunction

    logic [3:0]      first_nib;
    logic [8:0]      first_map;
    logic [IDXW-1:0] idx_next;
    logic [3:0]      next_nib;
    logic [8:0]      next_map;

    always_comb begin
        first_nib = bus.Bcd_in[4*DIGITS-1 -: 4];
        first_map = map_nibble(first_nib, 1'b0, ONE_DIGIT);
        idx_next  = idx - 1'b1;
        next_nib  = shadow[{idx_next, 2'b00} +: 4];
        next_map  = map_nibble(next_nib, seen_nz, (idx_next == '0));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            shadow   <= '0;
            idx      <= '0;
            seen_nz  <= 1'b0;
            ascii_q  <= 8'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef BCD_ASCII_CRLF_EN
            lf_phase <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        // The first character comes straight from Bcd_in so it is valid next cycle.
                        shadow  <= bus.Bcd_in;
                        idx     <= IDXW'(DIGITS - 1);
                        ascii_q <= first_map[7:0];
                        err_q   <= first_map[8];
                        seen_nz <= (first_nib != 4'd0);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (valid_q && bus.Ascii_ready) begin
                        if (idx == '0) begin
`ifdef BCD_ASCII_CRLF_EN
                            ascii_q  <= 8'd13;
                            lf_phase <= 1'b0;
                            state    <= S_TERM;
`else
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= S_FIN;
`endif
                        end else begin
                            ascii_q <= next_map[7:0];
                            err_q   <= err_q | next_map[8];
                            seen_nz <= seen_nz | (next_nib != 4'd0);
                            idx     <= idx_next;
                        end
                    end
                end
`ifdef BCD_ASCII_CRLF_EN
                S_TERM: begin
                    if (valid_q && bus.Ascii_ready) begin
                        if (!lf_phase) begin
                            ascii_q  <= 8'd10;
                            lf_phase <= 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= S_FIN;
                        end
                    end
                end
`endif
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Ascii_out   = ascii_q;
    assign bus.Ascii_valid = valid_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Err         = err_q;
    assign state_dbg       = state;
endmodule

// File: doc/bcd_ascii_streamer.md
BCD_ASCII_STREAMER -- requirements
Module: bcd_ascii_streamer

Interface
REQ-001 The block SHALL have parameter DIGITS, default 8, meaning the number of BCD digits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, meaning leading zeros are emitted as space (8'd32) when set.
REQ-003 The block SHALL have parameter HEX_MODE, default 0, meaning nibbles 10..15 are emitted as 'A'..'F' when set.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port Start, input, 1 bit: frame request, sampled only in IDLE.
REQ-007 The block SHALL have port Bcd_in, input, 4*DIGITS bits: packed digits, most significant digit (MSD) in the top nibble.
REQ-008 The block SHALL have port Ascii_out, output, 8 bits: the current character.
REQ-009 The block SHALL have port Ascii_valid, output, 1 bit: Ascii_out holds a valid character.
REQ-010 The block SHALL have port Ascii_ready, input, 1 bit: the sink accepts the character this cycle.
REQ-011 The block SHALL have port Busy, output, 1 bit: a frame is in progress.
REQ-012 The block SHALL have port Done, output, 1 bit: one-cycle pulse after the last character of a frame is accepted.
REQ-013 The block SHALL have port Err, output, 1 bit: an invalid digit was emitted in the current or last frame.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, TERM (CR then LF, present only under the configuration macro) and FIN.
REQ-015 In IDLE, Start=1 SHALL latch Bcd_in into a shadow register, clear Err, set Busy and enter SEND on the next edge.
REQ-016 Start SHALL be ignored while Busy=1, and changes on Bcd_in during a frame SHALL have no effect.
REQ-017 The first character SHALL be presented with Ascii_valid=1 on the cycle after Start is accepted (latency 1).
REQ-018 A character SHALL be transferred only on a cycle where Ascii_valid=1 and Ascii_ready=1; the next character, if any, is presented on the following cycle.
REQ-019 While Ascii_valid=1 and Ascii_ready=0, Ascii_out SHALL hold stable.
REQ-020 Digits SHALL be emitted in order MSD first, exactly DIGITS characters, using a digit index counter that runs from DIGITS-1 down to 0.
REQ-021 Nibbles 0..9 SHALL map to 8'd48..8'd57.
REQ-022 With HEX_MODE=1, nibbles 10..15 SHALL map to 8'd65..8'd70.
REQ-023 With HEX_MODE=0, nibbles 10..15 SHALL map to '?' (8'd63) and set Err.
REQ-024 With BLANK_LZ=1, zero digits preceding the first nonzero digit SHALL emit 8'd32; the least significant digit SHALL always be printed, so an all-zero frame ends in '0'.
REQ-025 An invalid nibble SHALL count as nonzero for blanking.
REQ-026 After the final character is accepted, the FSM SHALL enter FIN, assert Done for exactly one cycle, deassert Busy and return to IDLE.
REQ-027 Start=1 in the same cycle as the Done pulse SHALL be ignored; the earliest next frame starts from IDLE.
REQ-028 Err SHALL hold its value until the next accepted Start or RST.

Reset
REQ-029 RST=1 at a clock edge SHALL force IDLE, Ascii_out=8'd0, Ascii_valid=0, Busy=0, Done=0, Err=0, and clear the counter and shadow register.
REQ-030 RST takes priority over every other input; a reset mid-frame SHALL abort the frame silently, with no Done pulse.

Configuration
REQ-031 With macro BCD_ASCII_CRLF_EN defined, each frame SHALL append CR (8'd13) then LF (8'd10) after the last digit via TERM, under the same handshake, for DIGITS+2 characters per frame.
REQ-032 Without BCD_ASCII_CRLF_EN, TERM SHALL not exist and a frame SHALL be exactly DIGITS characters.

Verification
REQ-033 DIGITS=4, BLANK_LZ=1, Bcd_in=16'h0042, Ascii_ready=1 -> 32,32,52,50 on 4 consecutive cycles, Done one cycle later, Err=0.
REQ-034 DIGITS=4, Bcd_in=16'h0000 -> 32,32,32,48; with BLANK_LZ=0 -> 48,48,48,48.
REQ-035 HEX_MODE=0, Bcd_in=16'h1A03 -> 49,63,48,51 and Err=1 held until the next Start; with HEX_MODE=1 -> 49,65,48,51 and Err=0.
REQ-036 Ascii_ready toggling 0/1 every cycle during a 4-digit frame -> no character dropped or duplicated, Ascii_out stable while stalled.
REQ-037 RST asserted after 2 of 4 characters are accepted -> all outputs reset next cycle, no Done; a new Start then emits a full 4-character frame.
REQ-038 With BCD_ASCII_CRLF_EN, Bcd_in=16'h1234 -> 49,50,51,52,13,10 then Done; Start pulsed while Busy has no effect.
